// File: rtl/addrdecode_ordered_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : addrdecode_ordered_pkg
//  Brief    : Shared constants for the ordered address decoder: default slave
//             region table (8 equal regions on the top 3 address bits),
//             decode vector width and the index of the bus-error slave.
//  Revision : 1.0 - initial release
// ============================================================================
package addrdecode_ordered_pkg;

    localparam int unsigned c_NS_DEFAULT = 8;
    localparam int unsigned c_AW_DEFAULT = 32;

    // Decode vector carries one extra bit for "no slave matched".
    localparam int unsigned c_DEC_W   = c_NS_DEFAULT + 1;
    localparam int unsigned c_ERR_IDX = c_NS_DEFAULT;

    // Slave k owns [k*AW +: AW]; slave 0 sits in the least significant word.
    localparam logic [c_NS_DEFAULT*c_AW_DEFAULT-1:0] c_SLAVE_ADDR_DEFAULT = {
        32'hE000_0000, 32'hC000_0000, 32'hA000_0000, 32'h8000_0000,
        32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000
    };

    // Only the top three address bits select a region.
    localparam logic [c_NS_DEFAULT*c_AW_DEFAULT-1:0] c_SLAVE_MASK_DEFAULT =
        {c_NS_DEFAULT{32'hE000_0000}};

endpackage : addrdecode_ordered_pkg
`default_nettype wire

// File: rtl/addrdecode_ordered_skid.sv
`default_nettype none
// ============================================================================
//  Module   : addrdecode_ordered_skid
//  Brief    : One-entry skid buffer with a registered stall. Requests pass
//             straight through while the entry is empty; a request that the
//             downstream cannot take is parked and o_stall rises.
//  Revision : 1.0 - initial release
// ============================================================================
module addrdecode_ordered_skid #(
    parameter int DW = 70
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_stall,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_stall,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // Park an accepted request the downstream refuses; drain once it accepts.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
        end else if (i_valid && !r_valid && i_stall) begin
            r_valid <= 1'b1;
        end else if (!i_stall) begin
            r_valid <= 1'b0;
        end
    end

    // Capture the payload of every accepted request; only kept if parked.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= '0;
        end else if (i_valid && !r_valid) begin
            r_data <= i_data;
        end
    end

    assign o_stall = r_valid;
    assign o_valid = i_valid || r_valid;
    assign o_data  = r_valid ? r_data : i_data;

endmodule : addrdecode_ordered_skid
`default_nettype wire

// File: rtl/addrdecode_ordered.sv
`default_nettype none
// ============================================================================
//  Module   : addrdecode_ordered
//  Brief    : Registered address decoder for one master feeding an NS-slave
//             crossbar. Overlapping regions resolve to the lowest slave index,
//             unmatched addresses go to the bus-error slave (bit NS), and a
//             request to a different slave is held off while responses from
//             the previous slave are still outstanding.
//  Revision : 1.0 - initial release
// ============================================================================
module addrdecode_ordered
    import addrdecode_ordered_pkg::*;
#(
    parameter int                NS             = c_NS_DEFAULT,
    parameter int                AW             = c_AW_DEFAULT,
    parameter int                DW             = 38,
    parameter logic [NS*AW-1:0]  SLAVE_ADDR     = c_SLAVE_ADDR_DEFAULT,
    parameter logic [NS*AW-1:0]  SLAVE_MASK     = c_SLAVE_MASK_DEFAULT,
    parameter logic [NS-1:0]     ACCESS_ALLOWED = '1,
    parameter int                LGOUT          = 4,
    parameter bit                OPT_LOWPOWER   = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_stall,
    input  logic [AW-1:0]    i_addr,
    input  logic [DW-1:0]    i_data,
    output logic             o_valid,
    input  logic             i_stall,
    output logic [NS:0]      o_decode,
    output logic [AW-1:0]    o_addr,
    output logic [DW-1:0]    o_data,
    input  logic             i_rdone,
    output logic [LGOUT-1:0] o_outstanding,
    output logic             o_busy
);

    localparam logic [LGOUT-1:0] c_OUT_MAX = '1;

    // ------------------------------------------------------------------
    // Stage 1: skid buffer carrying {address, payload}
    // ------------------------------------------------------------------
    logic             w_s1_valid;
    logic             w_s1_stall;
    logic [AW+DW-1:0] w_s1_bundle;
    logic [AW-1:0]    w_s1_addr;
    logic [DW-1:0]    w_s1_payload;

    addrdecode_ordered_skid #(
        .DW (AW + DW)
    ) u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_stall (o_stall),
        .i_data  ({i_addr, i_data}),
        .o_valid (w_s1_valid),
        .i_stall (w_s1_stall),
        .o_data  (w_s1_bundle)
    );

    assign w_s1_addr    = w_s1_bundle[AW+DW-1:DW];
    assign w_s1_payload = w_s1_bundle[DW-1:0];

    // ------------------------------------------------------------------
    // Decode: per-slave region match, then lowest index wins
    // ------------------------------------------------------------------
    logic [NS-1:0] w_match;
    logic [NS:0]   w_next_decode;
    logic          w_found;

    for (genvar k = 0; k < NS; k++) begin : g_match
        assign w_match[k] = (((w_s1_addr ^ SLAVE_ADDR[k*AW +: AW])
                              & SLAVE_MASK[k*AW +: AW]) == '0)
                            && ACCESS_ALLOWED[k];
    end

    // Priority select; falls back to the bus-error slave so it stays onehot.
    always_comb begin
        w_next_decode = '0;
        w_found       = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (!w_found && w_match[k]) begin
                w_next_decode[k] = 1'b1;
                w_found          = 1'b1;
            end
        end
        if (!w_found) begin
            w_next_decode[NS] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hazard and stage-2 load control
    // ------------------------------------------------------------------
    logic             r_valid;
    logic [NS:0]      r_decode;
    logic [NS:0]      r_last_decode;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_data;
    logic [LGOUT-1:0] r_outstanding;

    logic w_hazard;
    logic w_s2_ready;
    logic w_load;

    // Switching slaves with responses in flight could reorder responses;
    // a full counter may only accept if a response retires this cycle.
    assign w_hazard   = ((r_outstanding != '0) && (w_next_decode != r_last_decode))
                        || ((r_outstanding == c_OUT_MAX) && !i_rdone);
    assign w_s2_ready = !r_valid || !i_stall;
    assign w_load     = w_s1_valid && w_s2_ready && !w_hazard;
    assign w_s1_stall = !w_load;

    // Stage-2 valid and slave select; decode always clears with valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid       <= 1'b0;
            r_decode      <= '0;
            r_last_decode <= '0;
        end else if (w_load) begin
            r_valid       <= 1'b1;
            r_decode      <= w_next_decode;
            r_last_decode <= w_next_decode;
        end else if (w_s2_ready) begin
            r_valid  <= 1'b0;
            r_decode <= '0;
        end
    end

    // Stage-2 address and payload; zeroed while idle only in low-power mode.
    always_ff @(posedge i_clk) begin
        if (OPT_LOWPOWER && i_reset) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_addr <= w_s1_addr;
            r_data <= w_s1_payload;
        end else if (OPT_LOWPOWER && w_s2_ready) begin
            r_addr <= '0;
            r_data <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-response counter (saturating, floored at zero)
    // ------------------------------------------------------------------
    logic w_cnt_inc;
    logic w_cnt_dec;

    assign w_cnt_inc = r_valid && !i_stall;
    assign w_cnt_dec = i_rdone && (r_outstanding != '0);

    // Count issued beats up and retired responses down; never wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_outstanding <= '0;
        end else if (w_cnt_inc && !w_cnt_dec) begin
            if (r_outstanding != c_OUT_MAX) begin
                r_outstanding <= r_outstanding + LGOUT'(1);
            end
        end else if (!w_cnt_inc && w_cnt_dec) begin
            r_outstanding <= r_outstanding - LGOUT'(1);
        end
    end

    assign o_valid       = r_valid;
    assign o_decode      = r_decode;
    assign o_addr        = r_addr;
    assign o_data        = r_data;
    assign o_outstanding = r_outstanding;
    assign o_busy        = (r_outstanding != '0);

endmodule : addrdecode_ordered
`default_nettype wire

// File: tb/tb_addrdecode_ordered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addrdecode_ordered
//  Brief    : Self-checking bench for addrdecode_ordered: directed scenarios
//             followed by randomized traffic, all compared every cycle with a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_addrdecode_ordered;

    localparam int NS    = 8;
    localparam int AW    = 32;
    localparam int DW    = 38;
    localparam int LGOUT = 2;
    localparam int MAXC  = 3;

    // Region table: slave 0 widened to cover slave 1's region (overlap),
    // slave 3 not permitted.
    localparam logic [31:0] BASE [8] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h6000_0000,
                                          32'h8000_0000, 32'hA000_0000, 32'hC000_0000, 32'hE000_0000};
    localparam logic [31:0] MASK [8] = '{32'hC000_0000, 32'hE000_0000, 32'hE000_0000, 32'hE000_0000,
                                          32'hE000_0000, 32'hE000_0000, 32'hE000_0000, 32'hE000_0000};
    localparam logic [7:0]  ALLOW    = 8'hF7;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_valid;
    logic             o_stall;
    logic [AW-1:0]    i_addr;
    logic [DW-1:0]    i_data;
    logic             o_valid;
    logic             i_stall;
    logic [NS:0]      o_decode;
    logic [AW-1:0]    o_addr;
    logic [DW-1:0]    o_data;
    logic             i_rdone;
    logic [LGOUT-1:0] o_outstanding;
    logic             o_busy;

    addrdecode_ordered #(
        .NS             (NS),
        .AW             (AW),
        .DW             (DW),
        .SLAVE_ADDR     ({32'hE000_0000, 32'hC000_0000, 32'hA000_0000, 32'h8000_0000,
                          32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({{6{32'hE000_0000}}, 32'hE000_0000, 32'hC000_0000}),
        .ACCESS_ALLOWED (ALLOW),
        .LGOUT          (LGOUT),
        .OPT_LOWPOWER   (1'b1)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .o_stall       (o_stall),
        .i_addr        (i_addr),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_stall       (i_stall),
        .o_decode      (o_decode),
        .o_addr        (o_addr),
        .o_data        (o_data),
        .i_rdone       (i_rdone),
        .o_outstanding (o_outstanding),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic [31:0] a;
        logic [37:0] d;
    } req_t;

    req_t        pend[$];      // accepted by the decoder, not yet issued
    bit          m_valid;
    logic [8:0]  m_dec;
    logic [31:0] m_addr;
    logic [37:0] m_data;
    logic [8:0]  m_last;
    int          m_count;
    bit          m_stall;

    function automatic logic [8:0] ref_decode(input logic [31:0] a);
        for (int k = 0; k < 8; k++) begin
            if (ALLOW[k] && ((a & MASK[k]) == BASE[k])) return 9'(1) << k;
        end
        return 9'h100;
    endfunction

    task automatic model_step();
        req_t       cur;
        bit         have, fromq, haz, ready, load, inc, dec;
        logic [8:0] nd;
        if (i_reset) begin
            pend.delete();
            m_valid = 0; m_dec = '0; m_addr = '0; m_data = '0;
            m_last = '0; m_count = 0;
        end else begin
            have = 0; fromq = 0; haz = 0; nd = '0;
            cur.a = '0; cur.d = '0;
            if (pend.size() > 0) begin
                cur = pend[0]; have = 1; fromq = 1;
            end else if (i_valid) begin
                cur.a = i_addr; cur.d = i_data; have = 1;
            end
            inc = m_valid && !i_stall;
            dec = i_rdone && (m_count > 0);
            if (have) begin
                nd  = ref_decode(cur.a);
                haz = ((m_count != 0) && (nd != m_last)) || ((m_count == MAXC) && !i_rdone);
            end
            ready = !m_valid || !i_stall;
            load  = have && ready && !haz;
            if (load) begin
                m_valid = 1; m_dec = nd; m_addr = cur.a; m_data = cur.d; m_last = nd;
                if (fromq) void'(pend.pop_front());
            end else begin
                if (ready) begin
                    m_valid = 0; m_dec = '0; m_addr = '0; m_data = '0;
                end
                if (have && !fromq) pend.push_back(cur);
            end
            m_count = m_count + (inc ? 1 : 0) - (dec ? 1 : 0);
            if (m_count > MAXC) m_count = MAXC;
        end
        m_stall = (pend.size() > 0);
    endtask

    task automatic compare_model();
        total++;
        if (o_valid !== m_valid || o_stall !== m_stall || o_decode !== m_dec ||
            o_addr !== m_addr || o_data !== m_data ||
            o_outstanding !== LGOUT'(m_count) || o_busy !== (m_count != 0)) begin
            bad++;
            $display("FAIL model t=%0t got v=%0b s=%0b dec=%h a=%h d=%h cnt=%0d busy=%0b want v=%0b s=%0b dec=%h a=%h d=%h cnt=%0d",
                     $time, o_valid, o_stall, o_decode, o_addr, o_data, o_outstanding, o_busy,
                     m_valid, m_stall, m_dec, m_addr, m_data, m_count);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, compare after.
    task automatic drv(input bit v, input logic [31:0] a, input bit st, input bit rd);
        logic [63:0] rnd;
        rnd     = {$urandom, $urandom};
        i_valid = v;
        i_addr  = a;
        i_data  = rnd[37:0];
        i_stall = st;
        i_rdone = rd;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        compare_model();
    endtask

    initial begin
        logic [2:0]  top;
        logic [31:0] a;
        bit          v, st, rd;

        i_reset = 1'b1; i_valid = 1'b0; i_addr = '0; i_data = '0;
        i_stall = 1'b0; i_rdone = 1'b0;
        repeat (3) drv(0, 32'h0, 0, 0);
        chk("reset_valid", 64'(o_valid), 64'h0);
        chk("reset_decode", 64'(o_decode), 64'h0);
        chk("reset_count", 64'(o_outstanding), 64'h0);
        chk("reset_stall", 64'(o_stall), 64'h0);
        i_reset = 1'b0;

        // Single request: one-cycle latency, counter follows the handoff.
        drv(1, 32'h4000_0000, 0, 0);
        chk("single_valid", 64'(o_valid), 64'h1);
        chk("single_decode", 64'(o_decode), 64'h004);
        chk("single_cnt0", 64'(o_outstanding), 64'h0);
        drv(0, 32'h0, 0, 0);
        chk("single_cnt1", 64'(o_outstanding), 64'h1);
        drv(0, 32'h0, 0, 1);

        // Overlap resolved to the lower index.
        drv(1, 32'h2000_0010, 0, 0);
        chk("overlap_decode", 64'(o_decode), 64'h001);
        drv(0, 32'h0, 0, 0);
        drv(0, 32'h0, 0, 1);

        // Disallowed slave 3 region falls to the bus-error slave.
        drv(1, 32'h6000_0000, 0, 0);
        chk("unmapped_decode", 64'(o_decode), 64'h100);
        drv(0, 32'h0, 0, 0);
        drv(0, 32'h0, 0, 1);

        // Ordering: slave 5 waits until both slave-2 responses retire.
        drv(1, 32'h4000_0000, 0, 0);
        drv(1, 32'h4000_0004, 0, 0);
        drv(1, 32'hA000_0000, 0, 0);
        chk("order_held_valid", 64'(o_valid), 64'h0);
        chk("order_held_stall", 64'(o_stall), 64'h1);
        chk("order_held_cnt", 64'(o_outstanding), 64'h2);
        drv(0, 32'h0, 0, 1);
        chk("order_still_held", 64'(o_valid), 64'h0);
        drv(0, 32'h0, 0, 1);
        chk("order_cnt_zero", 64'(o_outstanding), 64'h0);
        drv(0, 32'h0, 0, 0);
        chk("order_issue_dec", 64'(o_decode), 64'h020);
        chk("order_issue_stall", 64'(o_stall), 64'h0);
        drv(0, 32'h0, 0, 0);
        drv(0, 32'h0, 0, 1);

        // Saturation at 3 outstanding to slave 4.
        for (int k = 0; k < 3; k++) begin
            drv(1, 32'h8000_0000 + 32'(k), 0, 0);
            drv(0, 32'h0, 0, 0);
        end
        chk("sat_count", 64'(o_outstanding), 64'h3);
        drv(1, 32'h8000_0100, 0, 0);
        chk("sat_held_valid", 64'(o_valid), 64'h0);
        chk("sat_held_stall", 64'(o_stall), 64'h1);
        drv(0, 32'h0, 0, 1);
        chk("sat_release_valid", 64'(o_valid), 64'h1);
        chk("sat_release_addr", 64'(o_addr), 64'h8000_0100);
        drv(0, 32'h0, 0, 0);
        chk("sat_count_after", 64'(o_outstanding), 64'h3);
        repeat (3) drv(0, 32'h0, 0, 1);

        // Stall hold: outputs frozen, second request parked in the skid.
        drv(1, 32'h8000_0040, 0, 0);
        for (int k = 0; k < 5; k++) begin
            drv((k % 2) == 0, 32'h8000_0080 + 32'(k), 1, 0);
            chk("hold_addr", 64'(o_addr), 64'h8000_0040);
            chk("hold_decode", 64'(o_decode), 64'h010);
        end
        chk("hold_stall", 64'(o_stall), 64'h1);
        drv(0, 32'h0, 0, 0);
        chk("hold_next_addr", 64'(o_addr), 64'h8000_0080);

        // Reset in the middle of a stall.
        drv(0, 32'h0, 1, 0);
        i_reset = 1'b1;
        drv(0, 32'h0, 1, 0);
        i_reset = 1'b0;
        chk("mrst_valid", 64'(o_valid), 64'h0);
        chk("mrst_decode", 64'(o_decode), 64'h0);
        chk("mrst_addr", 64'(o_addr), 64'h0);
        chk("mrst_count", 64'(o_outstanding), 64'h0);
        drv(0, 32'h0, 0, 1);
        chk("mrst_stale_rdone", 64'(o_outstanding), 64'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            i_reset = ($urandom_range(0, 199) == 0);
            top = 3'($urandom_range(0, 7));
            a   = {top, 29'($urandom)};
            if ($urandom_range(0, 9) == 0) a = 32'h2000_0010;
            v  = ($urandom_range(0, 99) < 60);
            st = ($urandom_range(0, 99) < 30);
            rd = (m_count > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
            drv(v, a, st, rd);
        end
        i_reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_addrdecode_ordered
`default_nettype wire
